// File: rtl/rv32i_decode_stage.sv
// rtl/rv32i_decode_stage.sv - RV32I decode stage with skid buffer, halt FSM and retire counter
module rv32i_decode_stage #(
  parameter int unsigned COUNT_W  = 32,
  parameter logic [31:0] RESET_PC = 32'h00000400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_instr,
  output logic [6:0]         out_opcode,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [2:0]         out_funct3,
  output logic [6:0]         out_funct7,
  output logic [31:0]        out_imm,
  output logic [2:0]         out_fmt,
  output logic               out_illegal,
  output logic               halted,
  output logic [COUNT_W-1:0] retired_count
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  // The raw fields are slices of instr, so only the derived ones are kept
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } beat_t;

  state_t             r_state;
  state_t             w_state_next;
  beat_t              r_out;
  beat_t              r_skid;
  beat_t              w_dec;
  logic               r_out_valid;
  logic               r_skid_valid;
  logic [COUNT_W-1:0] r_count;
  logic [6:0]         w_op;
  logic [6:0]         w_f7;
  logic [2:0]         w_f3;
  logic [2:0]         w_fmt;
  logic [31:0]        w_imm;
  logic               w_ill;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_halt_beat;

  assign w_op = in_instr[6:0];
  assign w_f3 = in_instr[14:12];
  assign w_f7 = in_instr[31:25];

  // Classify the incoming word, build its immediate and flag bad encodings
  always_comb begin
    w_fmt = FMT_ILL;
    w_imm = '0;
    w_ill = 1'b0;
    case (w_op)
      OP_OP: begin
        w_fmt = FMT_R;
        w_ill = !((w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
      end
      OP_IMM: begin
        w_fmt = FMT_I;
        w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        w_ill = ((w_f3 == 3'b001) && (w_f7 != 7'b0000000)) ||
                ((w_f3 == 3'b101) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000));
      end
      OP_LOAD: begin
        w_fmt = FMT_I;
        w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        w_ill = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OP_JALR: begin
        w_fmt = FMT_I;
        w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        w_ill = (w_f3 != 3'b000);
      end
      OP_MISC: begin
        w_fmt = FMT_I;
        w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_SYSTEM: begin
        w_fmt = FMT_I;
        w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
        w_ill = (in_instr != 32'h00000073) && (in_instr != 32'h00100073);
      end
      OP_STORE: begin
        w_fmt = FMT_S;
        w_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        w_ill = (w_f3 >= 3'b011);
      end
      OP_BRANCH: begin
        w_fmt = FMT_B;
        w_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                 in_instr[11:8], 1'b0};
        w_ill = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OP_LUI, OP_AUIPC: begin
        w_fmt = FMT_U;
        w_imm = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        w_fmt = FMT_J;
        w_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                 in_instr[30:21], 1'b0};
      end
      default: w_ill = 1'b1;
    endcase
    if (w_ill) begin
      w_fmt = FMT_ILL;
      w_imm = '0;
    end
  end

  assign w_dec       = {in_pc, in_instr, w_imm, w_fmt, w_ill};
  assign w_halt_beat = w_ill || (w_op == OP_SYSTEM);
  assign in_ready    = !r_skid_valid && (r_state == ST_RUN);
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;

  // Output register: refill from skid first, else from the input, when empty or draining
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out.pc    <= RESET_PC;
      r_out_valid <= 1'b0;
    end else if (w_out_fire || !r_out_valid) begin
      if (r_skid_valid) begin
        r_out       <= r_skid;
        r_out_valid <= 1'b1;
      end else if (w_in_fire) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Skid entry: catches the beat accepted while the output is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_in_fire && r_out_valid && !w_out_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end else if (w_out_fire) begin
      r_skid_valid <= 1'b0;
    end
  end

  // Retired-beat counter, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_out_fire) begin
      r_count <= r_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Halt state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Stop accepting once a system or illegal beat has been taken
  always_comb begin
    w_state_next = r_state;
    if ((r_state == ST_RUN) && w_in_fire && w_halt_beat) begin
      w_state_next = ST_HALTED;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_pc        = r_out.pc;
  assign out_instr     = r_out.instr;
  assign out_opcode    = r_out.instr[6:0];
  assign out_rd        = r_out.instr[11:7];
  assign out_rs1       = r_out.instr[19:15];
  assign out_rs2       = r_out.instr[24:20];
  assign out_funct3    = r_out.instr[14:12];
  assign out_funct7    = r_out.instr[31:25];
  assign out_imm       = r_out.imm;
  assign out_fmt       = r_out.fmt;
  assign out_illegal   = r_out.illegal;
  assign halted        = (r_state == ST_HALTED);
  assign retired_count = r_count;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// tb/tb_rv32i_decode_stage.sv - self-checking bench for rv32i_decode_stage
module tb_rv32i_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        in_ready, out_valid, out_illegal, halted;
  logic [31:0] out_pc, out_instr, out_imm;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_fmt;
  logic [31:0] retired_count;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] m_q[$];
  bit          m_halted;
  int          m_retired;

  always #5 clk = ~clk;

  rv32i_decode_stage #(.COUNT_W(32), .RESET_PC(32'h00000400)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .halted(halted), .retired_count(retired_count)
  );

  function automatic void ref_dec(input logic [31:0] x, output logic [2:0] fmt,
                                  output logic [31:0] imm, output logic ill);
    int f3, f7, s;
    f3 = int'(x[14:12]);
    f7 = int'(x[31:25]);
    fmt = 3'd0; imm = '0; ill = 1'b0; s = 0;
    case (x[6:0])
      7'h33: ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      7'h13: begin fmt = 3'd1; imm = $signed(x) >>> 20;
                   ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32); end
      7'h03: begin fmt = 3'd1; imm = $signed(x) >>> 20; ill = (f3 == 3 || f3 >= 6); end
      7'h67: begin fmt = 3'd1; imm = $signed(x) >>> 20; ill = (f3 != 0); end
      7'h0f: begin fmt = 3'd1; imm = $signed(x) >>> 20; end
      7'h73: begin fmt = 3'd1; imm = $signed(x) >>> 20;
                   ill = !(x == 32'h00000073 || x == 32'h00100073); end
      7'h23: begin fmt = 3'd2; s = (($signed(x) >>> 25) * 32) + int'(x[11:7]);
                   imm = s; ill = (f3 >= 3); end
      7'h63: begin fmt = 3'd3;
                   s = (x[31] ? -4096 : 0) + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
                   imm = s; ill = (f3 == 2 || f3 == 3); end
      7'h37, 7'h17: begin fmt = 3'd4; imm = x & 32'hFFFFF000; end
      7'h6f: begin fmt = 3'd5;
                   s = (x[31] ? -(1 << 20) : 0) + int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2;
                   imm = s; end
      default: ill = 1'b1;
    endcase
    if (ill) begin fmt = 3'd7; imm = '0; end
  endfunction

  function automatic logic [31:0] gen_legal();
    logic [6:0]  ops[10];
    logic [31:0] x, im;
    logic [2:0]  f;
    logic        il;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0f, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
    for (int t = 0; t < 64; t++) begin
      x = $urandom;
      x[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 1) == 1) x[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      ref_dec(x, f, im, il);
      if (!il) return x;
    end
    return 32'h00500093;
  endfunction

  function automatic logic [31:0] gen_any();
    logic [6:0]  ops[11];
    logic [31:0] x;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0f, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73};
    x = $urandom;
    case ($urandom_range(0, 5))
      0: ;
      1: x = ($urandom_range(0, 1) == 1) ? 32'h00000073 : 32'h00100073;
      2: begin x[6:0] = ops[$urandom_range(0, 10)]; x[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
      default: x[6:0] = ops[$urandom_range(0, 10)];
    endcase
    return x;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_instr = '0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_q.delete(); m_halted = 1'b0; m_retired = 0;
  endtask

  // Advance one clock and update the reference model from the pre-edge inputs
  task automatic tick();
    logic acc, ret, il;
    logic [2:0] f;
    logic [31:0] im;
    acc = in_valid && (m_q.size() < 2) && !m_halted;
    ret = out_ready && (m_q.size() > 0);
    @(posedge clk);
    if (ret) begin void'(m_q.pop_front()); m_retired++; end
    if (acc) begin
      m_q.push_back({in_pc, in_instr});
      ref_dec(in_instr, f, im, il);
      if (il || in_instr[6:0] == 7'h73) m_halted = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_vec++; if (out_pc !== 32'h400) begin n_err++; $display("FAIL rst_out_pc got %h exp 00000400", out_pc); end
    n_vec++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL rst_out_instr got %h exp 0", out_instr); end
    n_vec++; if ({out_imm, out_fmt, out_illegal} !== 36'h0) begin n_err++; $display("FAIL rst_decode got imm=%h fmt=%0d ill=%b exp 0", out_imm, out_fmt, out_illegal); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %b exp 0", halted); end
    n_vec++; if (retired_count !== 32'h0) begin n_err++; $display("FAIL rst_count got %0d exp 0", retired_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_addi();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'h00500093;
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addi_valid got %b exp 1", out_valid); end
    n_vec++; if (out_fmt !== 3'd1) begin n_err++; $display("FAIL addi_fmt got %0d exp 1", out_fmt); end
    n_vec++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin n_err++; $display("FAIL addi_regs got rd=%0d rs1=%0d exp 1,0", out_rd, out_rs1); end
    n_vec++; if (out_imm !== 32'd5) begin n_err++; $display("FAIL addi_imm got %h exp 5", out_imm); end
    n_vec++; if (out_pc !== 32'h400) begin n_err++; $display("FAIL addi_pc got %h exp 400", out_pc); end
    tick();
    n_vec++; if (retired_count !== 32'd1) begin n_err++; $display("FAIL addi_count got %0d exp 1", retired_count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addi_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h404; in_instr = 32'h12345137;
    tick();
    in_pc = 32'h408; in_instr = 32'hFE208EE3;
    n_vec++; if (out_fmt !== 3'd4 || out_rd !== 5'd2) begin n_err++; $display("FAIL b2b_u got fmt=%0d rd=%0d exp 4,2", out_fmt, out_rd); end
    n_vec++; if (out_imm !== 32'h12345000) begin n_err++; $display("FAIL b2b_u_imm got %h exp 12345000", out_imm); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_fmt !== 3'd3 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin n_err++; $display("FAIL b2b_b got fmt=%0d rs1=%0d rs2=%0d exp 3,1,2", out_fmt, out_rs1, out_rs2); end
    n_vec++; if (out_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL b2b_b_imm got %h exp fffffffc", out_imm); end
    n_vec++; if (out_pc !== 32'h408 || retired_count !== 32'd1) begin n_err++; $display("FAIL b2b_second got pc=%h cnt=%0d exp 408,1", out_pc, retired_count); end
    tick();
    n_vec++; if (retired_count !== 32'd2) begin n_err++; $display("FAIL b2b_count got %0d exp 2", retired_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] b[4];
    logic [31:0] seen[$];
    int idx = 0;
    bit acc;
    do_reset();
    for (int i = 0; i < 4; i++) b[i] = gen_legal();
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_pc = 32'h700 + 32'(4 * idx); in_instr = b[idx];
      acc = (m_q.size() < 2) && !m_halted;
      tick();
      if (acc) idx++;
    end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h700 || out_instr !== b[0]) begin n_err++; $display("FAIL bp_hold got v=%b pc=%h instr=%h exp 1,700,%h", out_valid, out_pc, out_instr, b[0]); end
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) begin in_valid = 1'b1; in_pc = 32'h700 + 32'(4 * idx); in_instr = b[idx]; end
      else in_valid = 1'b0;
      if (out_valid === 1'b1) seen.push_back(out_pc);
      acc = in_valid && (m_q.size() < 2) && !m_halted;
      tick();
      if (acc) idx++;
    end
    n_vec++; if (seen.size() != 4) begin n_err++; $display("FAIL bp_count got %0d exp 4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      n_vec++; if (seen[i] !== 32'h700 + 32'(4 * i)) begin n_err++; $display("FAIL bp_order[%0d] got %h exp %h", i, seen[i], 32'h700 + 32'(4 * i)); end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h600; in_instr = 32'hFFFFFFFF;
    tick();
    in_pc = 32'h604; in_instr = 32'h00500093;
    n_vec++; if (out_illegal !== 1'b1 || out_fmt !== 3'd7 || out_imm !== 32'h0) begin n_err++; $display("FAIL ill_flags got ill=%b fmt=%0d imm=%h exp 1,7,0", out_illegal, out_fmt, out_imm); end
    n_vec++; if (halted !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL ill_halt got halted=%b in_ready=%b exp 1,0", halted, in_ready); end
    tick();
    tick();
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || retired_count !== 32'd1) begin n_err++; $display("FAIL ill_no_accept got v=%b cnt=%0d exp 0,1", out_valid, retired_count); end
  endtask

  task automatic test_ecall_skid();
    do_reset();
    in_valid = 1'b1; in_pc = 32'h500; in_instr = 32'h00500093;
    tick();
    in_pc = 32'h504; in_instr = 32'h00000073;
    tick();
    in_pc = 32'h508; in_instr = 32'h00100093;
    n_vec++; if (halted !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL ecall_halt got halted=%b in_ready=%b exp 1,0", halted, in_ready); end
    n_vec++; if (out_pc !== 32'h500) begin n_err++; $display("FAIL ecall_hold got %h exp 500", out_pc); end
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h504 || out_instr !== 32'h73 || out_fmt !== 3'd1) begin n_err++; $display("FAIL ecall_deliver got v=%b pc=%h instr=%h fmt=%0d exp 1,504,73,1", out_valid, out_pc, out_instr, out_fmt); end
    tick();
    n_vec++; if (out_valid !== 1'b0 || retired_count !== 32'd2 || halted !== 1'b1) begin n_err++; $display("FAIL ecall_end got v=%b cnt=%0d halted=%b exp 0,2,1", out_valid, retired_count, halted); end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_vec++; if (halted !== 1'b0 || retired_count !== 32'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL async_rst got halted=%b cnt=%0d in_ready=%b exp 0,0,1", halted, retired_count, in_ready); end
    n_vec++; if (out_valid !== 1'b0 || out_pc !== 32'h400 || out_instr !== 32'h0 || out_fmt !== 3'd0) begin n_err++; $display("FAIL async_rst_out got v=%b pc=%h instr=%h fmt=%0d exp 0,400,0,0", out_valid, out_pc, out_instr, out_fmt); end
    @(negedge clk);
    do_reset();
  endtask

  task automatic test_decode_sweep();
    logic [31:0] x, im;
    logic [2:0]  f;
    logic        il;
    for (int k = 0; k < 300; k++) begin
      do_reset();
      x = gen_any();
      ref_dec(x, f, im, il);
      out_ready = 1'b0; in_valid = 1'b1; in_pc = $urandom; in_instr = x;
      tick();
      in_valid = 1'b0;
      n_vec++; if (out_fmt !== f || out_imm !== im || out_illegal !== il) begin n_err++; $display("FAIL dec x=%h got fmt=%0d imm=%h ill=%b exp %0d,%h,%b", x, out_fmt, out_imm, out_illegal, f, im, il); end
      n_vec++; if ({out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7} !== {x[6:0], x[11:7], x[19:15], x[24:20], x[14:12], x[31:25]}) begin n_err++; $display("FAIL dec_fields x=%h got op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h", x, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7); end
      n_vec++; if (halted !== (il || x[6:0] == 7'h73)) begin n_err++; $display("FAIL dec_halt x=%h got %b exp %b", x, halted, (il || x[6:0] == 7'h73)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] cur_instr, im;
    logic [63:0] fr;
    logic [2:0]  f;
    logic        il;
    int sent = 0, cyc = 0;
    bit acc;
    do_reset();
    cur_instr = gen_legal();
    while (m_retired < 1000 && cyc < 20000) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_pc     = 32'h1000 + 32'(4 * sent);
      in_instr  = cur_instr;
      out_ready = ($urandom_range(0, 1) == 1);
      n_vec++; if (in_ready !== ((m_q.size() < 2) && !m_halted)) begin n_err++; $display("FAIL rnd_in_ready cyc=%0d got %b", cyc, in_ready); end
      n_vec++; if (out_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rnd_out_valid cyc=%0d got %b exp %b", cyc, out_valid, m_q.size() > 0); end
      n_vec++; if (retired_count !== 32'(m_retired)) begin n_err++; $display("FAIL rnd_count cyc=%0d got %0d exp %0d", cyc, retired_count, m_retired); end
      if (m_q.size() > 0) begin
        fr = m_q[0];
        ref_dec(fr[31:0], f, im, il);
        n_vec++; if ({out_pc, out_instr} !== fr || out_fmt !== f || out_imm !== im || out_illegal !== il) begin n_err++; $display("FAIL rnd_beat cyc=%0d got pc=%h instr=%h fmt=%0d imm=%h exp %h,%h,%0d,%h", cyc, out_pc, out_instr, out_fmt, out_imm, fr[63:32], fr[31:0], f, im); end
      end
      acc = in_valid && (m_q.size() < 2) && !m_halted;
      tick();
      if (acc) begin sent++; cur_instr = gen_legal(); end
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++; if (m_retired != 1000) begin n_err++; $display("FAIL rnd_budget got %0d retired exp 1000", m_retired); end
    n_vec++; if (retired_count !== 32'd1000) begin n_err++; $display("FAIL rnd_final_count got %0d exp 1000", retired_count); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_ecall_skid();
    test_decode_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
